// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters. An accepted request
// has its six operand fields registered onto the ALU_* bus. The bus is held
// for SETTLE cycles, then the ALU return is captured into RESULT/SIG_B. A
// one-cycle VLD pulse goes back to the requester that was granted.
//
// Parameter
//   SETTLE          cycles the ALU_* bus is held before capture (1..15)
//
// Ports
//   CLK, RST        clock; synchronous active-high reset
//   REQ0/1          request from requester 0 / 1
//   OPCODE*, FUNC*, SHAMT*, RAW*, RS*, RT*   per-requester operand fields
//   GNT0/1          one-cycle pulse: request accepted, operands captured
//   VLD0/1          one-cycle pulse: RESULT/SIG_B valid for that requester
//   RESULT, SIG_B   registered ALU result and branch-taken flag
//   BUSY            high whenever a transaction is in flight
//   ALU_*           registered operand bus driven to the shared ALU
//   ALU_RESULT, ALU_SIG_B   combinational return from the shared ALU
//
// Configuration macro
//   ALU_ARB_FIXED_PRIO_EN   defined: ties always go to requester 0.
//                           undefined: ties are resolved round robin.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic [5:0]  OPCODE0,
  input  logic [5:0]  FUNC0,
  input  logic [4:0]  SHAMT0,
  input  logic [15:0] RAW0,
  input  logic [31:0] RS0,
  input  logic [31:0] RT0,
  input  logic [5:0]  OPCODE1,
  input  logic [5:0]  FUNC1,
  input  logic [4:0]  SHAMT1,
  input  logic [15:0] RAW1,
  input  logic [31:0] RS1,
  input  logic [31:0] RT1,
  output logic        GNT0,
  output logic        GNT1,
  output logic        VLD0,
  output logic        VLD1,
  output logic [31:0] RESULT,
  output logic        SIG_B,
  output logic        BUSY,
  output logic [5:0]  ALU_OPCODE,
  output logic [5:0]  ALU_FUNC,
  output logic [4:0]  ALU_SHAMT,
  output logic [15:0] ALU_RAW,
  output logic [31:0] ALU_RS,
  output logic [31:0] ALU_RT,
  input  logic [31:0] ALU_RESULT,
  input  logic        ALU_SIG_B
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;   // requester of the transaction in flight
  logic        gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic        vld0_q, vld0_d, vld1_q, vld1_d;
  logic [31:0] result_q, result_d;
  logic        sig_b_q, sig_b_d;
  logic [5:0]  opc_q, opc_d, func_q, func_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [15:0] raw_q, raw_d;
  logic [31:0] rs_q, rs_d, rt_q, rt_d;

  logic accept;  // a request is taken on this edge
  logic pick1;   // requester 1 wins if a request is taken

  assign accept = (state_q == IDLE) && (REQ0 || REQ1);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick1 = REQ1 && !REQ0;
`else
  // Index granted most recently; reset to 1 so requester 0 wins the first tie.
  logic last_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      last_q <= 1'b1;
    end else if (accept) begin
      last_q <= pick1;
    end
  end

  // On a tie, grant whichever requester was not granted last.
  assign pick1 = REQ1 && (!REQ0 || !last_q);
`endif

  always_comb begin
    // NOTE: every next-state signal gets a hold/idle default before the case,
    // so no path through the block can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    vld0_d   = 1'b0;
    vld1_d   = 1'b0;
    result_d = result_q;
    sig_b_d  = sig_b_q;
    opc_d    = opc_q;
    func_d   = func_q;
    shamt_d  = shamt_q;
    raw_d    = raw_q;
    rs_d     = rs_q;
    rt_d     = rt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          opc_d   = pick1 ? OPCODE1 : OPCODE0;
          func_d  = pick1 ? FUNC1   : FUNC0;
          shamt_d = pick1 ? SHAMT1  : SHAMT0;
          raw_d   = pick1 ? RAW1    : RAW0;
          rs_d    = pick1 ? RS1     : RS0;
          rt_d    = pick1 ? RT1     : RT0;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          owner_d = pick1;
          cnt_d   = 4'd0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          result_d = ALU_RESULT;
          // Only branches produce a meaningful taken flag.
          sig_b_d  = ((opc_q == OP_BEQ) || (opc_q == OP_BNE)) && ALU_SIG_B;
          vld0_d   = !owner_q;
          vld1_d   = owner_q;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    // NOTE: reset is synchronous and sampled here, so RST dominates any
    // request on the same edge and aborts a transaction in flight.
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      owner_q  <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      vld0_q   <= 1'b0;
      vld1_q   <= 1'b0;
      result_q <= 32'd0;
      sig_b_q  <= 1'b0;
      opc_q    <= 6'd0;
      func_q   <= 6'd0;
      shamt_q  <= 5'd0;
      raw_q    <= 16'd0;
      rs_q     <= 32'd0;
      rt_q     <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values that held before the edge, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      vld0_q   <= vld0_d;
      vld1_q   <= vld1_d;
      result_q <= result_d;
      sig_b_q  <= sig_b_d;
      opc_q    <= opc_d;
      func_q   <= func_d;
      shamt_q  <= shamt_d;
      raw_q    <= raw_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
    end
  end

  assign GNT0       = gnt0_q;
  assign GNT1       = gnt1_q;
  assign VLD0       = vld0_q;
  assign VLD1       = vld1_q;
  assign RESULT     = result_q;
  assign SIG_B      = sig_b_q;
  assign BUSY       = (state_q != IDLE);
  assign ALU_OPCODE = opc_q;
  assign ALU_FUNC   = func_q;
  assign ALU_SHAMT  = shamt_q;
  assign ALU_RAW    = raw_q;
  assign ALU_RS     = rs_q;
  assign ALU_RT     = rt_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter SETTLE, default 1, number of cycles ALU inputs are held stable before the result is captured; legal range 1..15.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 REQ0, REQ1  input  1 each  operation request from requester 0 / 1.
REQ-005 OPCODE0/1, FUNC0/1  input  6 each  instruction opcode and function field per requester.
REQ-006 SHAMT0/1  input  5 each; RAW0/1  input  16 each  immediate field per requester.
REQ-007 RS0/1, RT0/1  input  32 each  source operand values per requester.
REQ-008 GNT0, GNT1  output  1 each  one-cycle pulse: request accepted, operands captured.
REQ-009 VLD0, VLD1  output  1 each  one-cycle pulse: RESULT/SIG_B valid for that requester.
REQ-010 RESULT  output  32  registered ALU result; SIG_B  output  1  registered branch-taken flag.
REQ-011 BUSY  output  1  high whenever state is not IDLE.
REQ-012 ALU_OPCODE 6, ALU_FUNC 6, ALU_SHAMT 5, ALU_RAW 16, ALU_RS 32, ALU_RT 32  outputs  registered operand bus to the shared ALU.
REQ-013 ALU_RESULT  input  32; ALU_SIG_B  input  1  combinational return from the shared ALU.

Function
REQ-014 FSM states IDLE, DRIVE, RESP; exactly one active.
REQ-015 IDLE, edge with REQ0|REQ1: winner's six operand fields latched onto ALU_* bus, GNTn=1 for the following cycle, counter=0, state->DRIVE.
REQ-016 IDLE, no request: stay IDLE; ALU_* bus holds last values.
REQ-017 Both requests in the same IDLE edge: grant the requester not granted last (round robin); single request granted regardless of pointer.
REQ-018 Requests while BUSY are ignored (not queued); requester holds REQ until it sees GNT; REQ dropped before acceptance produces no grant.
REQ-019 DRIVE: counter increments each edge; on the edge where counter==SETTLE-1, RESULT<=ALU_RESULT, SIG_B<=masked ALU_SIG_B, VLDn=1 for the granted requester, state->RESP.
REQ-020 SIG_B mask: ALU_SIG_B passed only when latched ALU_OPCODE is 6'b000100 (beq) or 6'b000101 (bne); otherwise SIG_B captured as 0.
REQ-021 RESP: next edge VLDn<=0, state->IDLE; RESULT/SIG_B hold until next capture.
REQ-022 Latency: GNT high cycle after accept edge; VLD high SETTLE cycles after GNT; next accept no earlier than SETTLE+2 edges after previous accept.
REQ-023 GNT0/GNT1 never high together; VLD0/VLD1 never high together; VLDn only follows GNTn of the same transaction.
REQ-024 Opcodes/functions not recognised by the ALU are forwarded unchanged; arbiter performs no decode beyond REQ-020.
REQ-025 Round-robin pointer LAST updates to the granted index on every accept.

Reset
REQ-026 RST at any edge, any state: state->IDLE, counter=0, GNT0/1=0, VLD0/1=0, RESULT=0, SIG_B=0, all ALU_* outputs=0, LAST=1 (requester 0 wins first tie).
REQ-027 Reset mid-DRIVE/RESP aborts the transaction: no VLD pulse for it; RST dominates REQ on the same edge.

Configuration
REQ-028 Macro ALU_ARB_FIXED_PRIO_EN defined: ties always granted to requester 0, LAST unused; undefined: round robin per REQ-017/025.

Verification
REQ-029 SETTLE=1, REQ0 with OPCODE0=0, FUNC0=6'b100000, RS0=5, RT0=7 -> GNT0 next cycle, VLD0 one cycle later, RESULT=12, SIG_B=0.
REQ-030 REQ0 and REQ1 held high continuously, default build -> grants alternate 0,1,0,1; with ALU_ARB_FIXED_PRIO_EN -> GNT0 every accept, GNT1 never.
REQ-031 REQ1 beq OPCODE1=6'b000100, RS1=RT1=9 -> VLD1, SIG_B=1; then addi OPCODE0=6'b001000, RS0=1, RAW0=16'hFFFF -> RESULT=0, SIG_B=0.
REQ-032 SETTLE=3, single add -> VLD exactly 3 cycles after GNT; REQ asserted while BUSY -> no GNT until IDLE.
REQ-033 RST asserted one cycle after GNT0 -> no VLD0, all outputs 0 next edge; pending REQ1 and REQ0 together after reset -> GNT0 first.
